// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage of the 5-stage NPC core.
// Owns the PC and drives it to the combinational instruction memory as RdAddr.
// It captures the returned word together with its PC in the IF/ID slot.
// Execute-stage redirects take priority over every other event.
// A misaligned redirect target produces one faulted slot, and fetch then halts
// until the next redirect arrives.
//
// Optional feature macro: FETCH_STATIC_PREDICT_EN
//   When defined, JAL and backward B-type instructions are predicted taken.
//   When undefined, the next PC is always pc + 4 and if_pred_taken is tied to 0.
//
// Handshake (IF/ID slot): if_valid means the slot holds an instruction.
// The consumer takes it on any edge where id_ready is high. The slot is "free"
// when (!if_valid || id_ready). Slot outputs only change at an edge where the
// slot is free or a redirect is taken, so they are stable while
// if_valid && !id_ready.

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] RdAddr,
    input  logic [31:0] Instr,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken,
    output logic        if_fault
);

    // Fetch control states:
    //   RUN        : normal sequential or predicted fetching.
    //   FAULT_PEND : the misaligned-fetch fault slot is waiting for decode.
    //   FAULT_IDLE : the fault has been handed over and fetch is halted.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FAULT_PEND = 2'd1,
        ST_FAULT_IDLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic        pred_q, pred_d;
    logic        fault_q, fault_d;

    logic        slot_free;
    logic        redirect_misaligned;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        pred_hit;

    // The memory address is the architectural fetch PC itself. There is no
    // extra register stage.
    assign RdAddr = pc_q;

    // The slot accepts new content when it is empty or being consumed this cycle.
    assign slot_free           = !valid_q || id_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // The sequential successor wraps modulo 2^32 because the 32-bit adder
    // carries no extra bit.
    assign seq_pc = pc_q + 32'd4;

`ifdef FETCH_STATIC_PREDICT_EN
    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] target_j;
    logic [31:0] target_b;
    logic        is_jal;
    logic        is_branch_back;
    logic        jal_ok;
    logic        branch_ok;

    // Static predictor: JAL is always taken, and backward conditional branches
    // are assumed to close loops.
    always_comb begin
        opcode         = Instr[6:0];
        imm_j          = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
        imm_b          = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
        target_j       = pc_q + imm_j;
        target_b       = pc_q + imm_b;
        is_jal         = (opcode == 7'b1101111);
        is_branch_back = (opcode == 7'b1100011) && Instr[31];
        // A target that would itself fault is not predicted. Execute
        // resolves it with a redirect instead.
        jal_ok         = is_jal && (target_j[1:0] == 2'b00);
        branch_ok      = is_branch_back && (target_b[1:0] == 2'b00);
        pred_hit       = jal_ok || branch_ok;
        if (jal_ok) begin
            next_pc = target_j;
        end else if (branch_ok) begin
            next_pc = target_b;
        end else begin
            next_pc = seq_pc;
        end
    end
`else
    // Without prediction the fetch stream is strictly sequential.
    assign pred_hit = 1'b0;
    assign next_pc  = seq_pc;
`endif

    // Next-state logic for the PC, the IF/ID slot and the fetch control state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        pred_d       = pred_q;
        fault_d      = fault_q;

        if (redirect_valid) begin
            // The redirect wins over stalls and fault states. The word fetched
            // this cycle belongs to the wrong path and is dropped.
            pc_d   = redirect_pc;
            pred_d = 1'b0;
            if (redirect_misaligned) begin
                // Hand decode a single faulted slot carrying the offending PC.
                state_d      = ST_FAULT_PEND;
                valid_d      = 1'b1;
                fault_d      = 1'b1;
                slot_pc_d    = redirect_pc;
                slot_instr_d = NOP_INSTR;
            end else begin
                state_d = ST_RUN;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (slot_free) begin
                        valid_d      = 1'b1;
                        slot_pc_d    = pc_q;
                        slot_instr_d = Instr;
                        pred_d       = pred_hit;
                        fault_d      = 1'b0;
                        pc_d         = next_pc;
                    end
                    // If the slot is not free, everything holds and memory
                    // is simply read again at the same address.
                end
                ST_FAULT_PEND: begin
                    if (id_ready) begin
                        valid_d = 1'b0;
                        fault_d = 1'b0;
                        state_d = ST_FAULT_IDLE;
                    end
                end
                ST_FAULT_IDLE: begin
                    // Halted: only a redirect restarts fetching.
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State registers. An asynchronous reset drops any in-flight slot and
    // fault immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            slot_pc_q    <= 32'h0;
            slot_instr_q <= 32'h0;
            pred_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            pred_q       <= pred_d;
            fault_q      <= fault_d;
        end
    end

    assign if_valid      = valid_q;
    assign if_pc         = slot_pc_q;
    assign if_instr      = slot_instr_q;
    assign if_pred_taken = pred_q;
    assign if_fault      = fault_q;

endmodule
